count_sequencer: RTL and testbench
==================================

// Module: count_sequencer
// PURPOSE
//  Central controller for the up/down counter_fsm pair. Sequences runs through their go/done handshake.
//  Supports ping-pong, up-only and down-only modes, a finite or endless pass count, graceful stop and a done watchdog.
//  Registers the LED mux. Sits between the clock divider tick and the two counters; replaces ad-hoc top-level glue.
// PARAMETERS
//  PASS_W   8   width of pass counter
//  PASSES   0   runs before auto-stop; 0 = endless
//  TO_W     6   width of watchdog counter
//  TIMEOUT  40  ticks allowed in a RUN state before fault (>= 17 for 4-bit counter)
// PORTS
//  clk        in   1       system clock
//  rst_btn    in   1       asynchronous, active-low reset
//  tick       in   1       one-clk enable pulse from clock divider; FSM advances only when tick=1
//  start      in   1       level; begin sequence (sampled on tick)
//  stop       in   1       level; request graceful stop (sampled on tick, latched)
//  clear      in   1       level; leave FAULT (sampled on tick)
//  mode       in   2       0=PINGPONG 1=UP_ONLY 2=DOWN_ONLY 3=reserved(treated as PINGPONG)
//  up_done    in   1       done from up counter
//  down_done  in   1       done from down counter
//  up_out     in   4       up counter value
//  down_out   in   4       down counter value
//  up_go      out  1       go to up counter, high for exactly one tick period
//  down_go    out  1       go to down counter, high for exactly one tick period
//  led        out  4       registered display value
//  busy       out  1       high in any state except IDLE/FAULT
//  fault      out  1       watchdog expired
//  pass_cnt   out  PASS_W  completed runs since start (wraps at 2^PASS_W when PASSES=0)
// BEHAVIOUR
//  Reset (rst_btn=0, async): state=IDLE.
//    All outputs 0: up_go=down_go=0, led=0, busy=0, fault=0, pass_cnt=0. Stop latch and watchdog are cleared.
//  All transitions occur on posedge clk with tick=1; with tick=0 every register holds.
//  States: IDLE, UP_GO, UP_RUN, DN_GO, DN_RUN, FAULT.
//  IDLE:
//    start & ~stop -> UP_GO (DN_GO if mode=DOWN_ONLY); pass_cnt<=0.
//    start & stop simultaneously: stop wins; stay IDLE.
//  UP_GO / DN_GO:
//    up_go / down_go =1 for this one tick period; next -> UP_RUN / DN_RUN. Watchdog <= 0.
//  UP_RUN / DN_RUN: watchdog increments each tick.
//    On the matching done: pass_cnt+1, then choose next state in this order:
//      - stop latched, or (PASSES!=0 & new pass_cnt==PASSES) -> IDLE.
//      - PINGPONG: UP_RUN->DN_GO, DN_RUN->UP_GO.
//      - UP_ONLY -> UP_GO.
//      - DOWN_ONLY -> DN_GO.
//    A done arriving in the same tick the watchdog reaches TIMEOUT: done wins.
//    Non-matching done (e.g. down_done in UP_RUN) is ignored.
//  Watchdog reaches TIMEOUT-1 without done -> FAULT; fault=1, led=4'hF.
//  FAULT: only clear leaves it (-> IDLE, fault=0); start is ignored here.
//  stop: sampled on tick while busy, latched until IDLE is reached; the current run always completes.
//  mode: sampled only at run completion or IDLE exit; a change mid-run does not abort the run.
//  led: registered, one tick behind the counter:
//    up_out in UP_GO/UP_RUN; down_out in DN_GO/DN_RUN; 0 in IDLE; 4'hF in FAULT.
//  pass_cnt: modulo-2^PASS_W add; holds its value in IDLE so it can be read back.
//  Reset mid-run: immediate return to IDLE; go outputs drop asynchronously.
// STRUCTURE
//  count_defs.vh, shared include: localparams for MODE_PINGPONG/UP_ONLY/DOWN_ONLY and the state encodings.
//    The top level and testbench use the same names.
//  Sub-module tick_watchdog (clk, rst_btn, tick, clr, expired; params TO_W, TIMEOUT).
//    Counter reused by other tick-driven blocks.
//  FSM, stop latch, pass counter and LED register stay in this module.
// TESTING  (tick every 4 clk; behavioural counter models asserting done after 16 ticks)
//  1 mode=0, PASSES=0, start pulse:
//    up_go, then ~16 ticks later down_go; alternation continues; pass_cnt = 1,2,3...
//    led follows up_out then down_out.
//  2 mode=1, PASSES=3:
//    exactly three up_go pulses and no down_go; then IDLE, busy=0, pass_cnt=3 held.
//  3 stop raised mid UP_RUN in mode 0:
//    up run finishes, pass_cnt+1, no down_go issued, IDLE.
//    start & stop in the same tick in IDLE -> no go.
//  4 done withheld for 40 ticks:
//    FAULT, fault=1, led=4'hF; start ignored; clear -> IDLE, fault=0.
//    done on the expiry tick -> no fault.
//  5 rst_btn low mid DN_RUN, asynchronous to clk:
//    all outputs 0 before the next clk edge.
//    Release and start -> normal up_go.
//  6 tick held low:
//    state, led and go outputs frozen regardless of start/done activity.

Source files
------------

// File: rtl/count_sequencer_pkg.sv
// Shared names for the count sequencer: run modes, FSM states and the
// next-go selection used when a run completes or the sequence starts.
package count_sequencer_pkg;

    typedef enum logic [1:0] {
        MODE_PINGPONG  = 2'd0,
        MODE_UP_ONLY   = 2'd1,
        MODE_DOWN_ONLY = 2'd2,
        MODE_RSVD      = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UP_GO  = 3'd1,
        ST_UP_RUN = 3'd2,
        ST_DN_GO  = 3'd3,
        ST_DN_RUN = 3'd4,
        ST_FAULT  = 3'd5
    } state_e;

    localparam logic [3:0] LED_FAULT = 4'hF;

    // from_up=0 doubles as the IDLE-exit case: pingpong always opens upward.
    function automatic state_e next_go(input mode_e m, input logic from_up);
        case (m)
            MODE_UP_ONLY:   next_go = ST_UP_GO;
            MODE_DOWN_ONLY: next_go = ST_DN_GO;
            default:        next_go = from_up ? ST_DN_GO : ST_UP_GO;
        endcase
    endfunction

endpackage

// File: rtl/count_sequencer_tick_watchdog.sv
// Tick-driven watchdog: counts ticks while clr is low and flags when the
// count reaches TIMEOUT-1, i.e. on the TIMEOUT-th counted tick.
module tick_watchdog #(
    parameter int TO_W    = 6,
    parameter int TIMEOUT = 40
) (
    input  logic clk,
    input  logic rst_btn,
    input  logic tick,
    input  logic clr,
    output logic expired
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            cnt <= '0;
        end else if (tick) begin
            if (clr)
                cnt <= '0;
            else if (!expired)
                cnt <= cnt + TO_W'(1);
        end
    end

    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/count_sequencer.sv
// Sequencer for the up/down counter pair: go/done handshake, pass counting,
// graceful stop, done watchdog and the registered LED mux.
module count_sequencer
    import count_sequencer_pkg::*;
#(
    parameter int PASS_W  = 8,
    parameter int PASSES  = 0,
    parameter int TO_W    = 6,
    parameter int TIMEOUT = 40
) (
    input  logic              clk,
    input  logic              rst_btn,
    input  logic              tick,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    input  logic [1:0]        mode,
    input  logic              up_done,
    input  logic              down_done,
    input  logic [3:0]        up_out,
    input  logic [3:0]        down_out,
    output logic              up_go,
    output logic              down_go,
    output logic [3:0]        led,
    output logic              busy,
    output logic              fault,
    output logic [PASS_W-1:0] pass_cnt
);

    localparam logic [PASS_W-1:0] PASS_LIM = PASS_W'(PASSES);

    state_e            state, state_next;
    mode_e             mode_m;
    logic              stop_l, stop_eff;
    logic              run_done, run_up, last_pass;
    logic              wd_clr, wd_expired;
    logic [PASS_W-1:0] pass_inc;

    assign mode_m    = mode_e'(mode);
    assign run_up    = (state == ST_UP_RUN);
    assign run_done  = (state == ST_UP_RUN && up_done) || (state == ST_DN_RUN && down_done);
    assign pass_inc  = pass_cnt + PASS_W'(1);
    assign stop_eff  = stop_l | stop;
    assign last_pass = (PASSES != 0) && (pass_inc == PASS_LIM);

    tick_watchdog #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .clk     (clk),
        .rst_btn (rst_btn),
        .tick    (tick),
        .clr     (wd_clr),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn)
            state <= ST_IDLE;
        else if (tick)
            state <= state_next;
    end

    // A done on the expiry tick is checked first, so it beats the watchdog.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start && !stop) state_next = next_go(mode_m, 1'b0);
            ST_UP_GO:  state_next = ST_UP_RUN;
            ST_DN_GO:  state_next = ST_DN_RUN;
            ST_UP_RUN,
            ST_DN_RUN: begin
                if (run_done)
                    state_next = (stop_eff || last_pass) ? ST_IDLE : next_go(mode_m, run_up);
                else if (wd_expired)
                    state_next = ST_FAULT;
            end
            ST_FAULT:  if (clear) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        up_go   = 1'b0;
        down_go = 1'b0;
        busy    = 1'b0;
        fault   = 1'b0;
        wd_clr  = 1'b1;
        case (state)
            ST_UP_GO:  begin up_go = 1'b1;   busy = 1'b1; end
            ST_DN_GO:  begin down_go = 1'b1; busy = 1'b1; end
            ST_UP_RUN,
            ST_DN_RUN: begin busy = 1'b1;    wd_clr = 1'b0; end
            ST_FAULT:  fault = 1'b1;
            default:   ;
        endcase
    end

    // LED follows the state being entered so fault and 4'hF appear together.
    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            pass_cnt <= '0;
            stop_l   <= 1'b0;
            led      <= '0;
        end else if (tick) begin
            if (state == ST_IDLE && state_next != ST_IDLE)
                pass_cnt <= '0;
            else if (run_done)
                pass_cnt <= pass_inc;

            if (state_next == ST_IDLE || state_next == ST_FAULT)
                stop_l <= 1'b0;
            else if (busy)
                stop_l <= stop_eff;

            case (state_next)
                ST_UP_GO, ST_UP_RUN: led <= up_out;
                ST_DN_GO, ST_DN_RUN: led <= down_out;
                ST_FAULT:            led <= LED_FAULT;
                default:             led <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: an endless (PASSES=0) and a finite (PASSES=3)
// instance share all inputs and are each tracked by a run-level model.
module tb_count_sequencer;
    import count_sequencer_pkg::*;

    localparam int TIMEOUT = 40;
    localparam int P_IDLE = 0, P_GO = 1, P_RUN = 2, P_FAULT = 3;

    logic clk = 0, rst_btn = 0, tick = 0, start = 0, stop = 0, clear = 0;
    logic up_done = 0, down_done = 0;
    logic [1:0] mode = 0;
    logic [3:0] up_out = 0, down_out = 0;
    logic [1:0] ugo, dgo, bsy, flt;
    logic [1:0][3:0] ledo;
    logic [1:0][7:0] pco;

    always #5 clk = ~clk;

    count_sequencer #(.PASS_W(8), .PASSES(0), .TO_W(6), .TIMEOUT(TIMEOUT)) dut0 (
        .clk(clk), .rst_btn(rst_btn), .tick(tick), .start(start), .stop(stop),
        .clear(clear), .mode(mode), .up_done(up_done), .down_done(down_done),
        .up_out(up_out), .down_out(down_out), .up_go(ugo[0]), .down_go(dgo[0]),
        .led(ledo[0]), .busy(bsy[0]), .fault(flt[0]), .pass_cnt(pco[0]));

    count_sequencer #(.PASS_W(8), .PASSES(3), .TO_W(6), .TIMEOUT(TIMEOUT)) dut1 (
        .clk(clk), .rst_btn(rst_btn), .tick(tick), .start(start), .stop(stop),
        .clear(clear), .mode(mode), .up_done(up_done), .down_done(down_done),
        .up_out(up_out), .down_out(down_out), .up_go(ugo[1]), .down_go(dgo[1]),
        .led(ledo[1]), .busy(bsy[1]), .fault(flt[1]), .pass_cnt(pco[1]));

    int checks = 0, errors = 0;
    bit model_on, use_cnt, auto_tick;
    int sel, tphase;
    bit tick_pre, go_u_pre, go_d_pre;

    // Model: phase of the sequence, direction of the current run, ticks spent running.
    int m_phase[2], m_wd[2], m_pass[2], m_led[2];
    bit m_up[2], m_stop[2];
    int passes_of[2] = '{0, 3};

    // Behavioural counters: done after 16 ticks following a go.
    int uc, dc;
    bit ua, da;
    int rise_u[2], rise_d[2];
    bit prev_u[2], prev_d[2];

    typedef struct {
        logic tk, st, sp, cl;
        logic [1:0] md;
        logic ud, dd;
        logic [3:0] uo, dn;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl[15];

    function automatic logic [15:0] ex(bit ug, bit dg, bit b, bit f, logic [3:0] l, logic [7:0] p);
        return {ug, dg, b, f, l, p};
    endfunction

    function automatic vec_t mk(bit tk, bit st, bit sp, bit cl, logic [1:0] md, bit ud, bit dd,
                                logic [3:0] uo, logic [3:0] dn, logic [15:0] e);
        vec_t v;
        v.tk = tk; v.st = st; v.sp = sp; v.cl = cl; v.md = md; v.ud = ud; v.dd = dd;
        v.uo = uo; v.dn = dn; v.exp = e;
        return v;
    endfunction

    function automatic logic [15:0] dv(int i);
        return {ugo[i], dgo[i], bsy[i], flt[i], ledo[i], pco[i]};
    endfunction

    function automatic logic [15:0] mv(int i);
        bit g;
        g = (m_phase[i] == P_GO);
        return {g && m_up[i], g && !m_up[i], (m_phase[i] == P_GO || m_phase[i] == P_RUN),
                m_phase[i] == P_FAULT, 4'(m_led[i]), 8'(m_pass[i])};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = P_IDLE; m_wd[i] = 0; m_pass[i] = 0; m_led[i] = 0;
            m_up[i] = 0; m_stop[i] = 0;
            rise_u[i] = 0; rise_d[i] = 0; prev_u[i] = 0; prev_d[i] = 0;
        end
        uc = 0; dc = 0; ua = 0; da = 0;
    endtask

    task automatic model_step(int i);
        int ph;
        bit se;
        if (tick) begin
            ph = m_phase[i];
            se = m_stop[i] || stop;
            case (ph)
                P_IDLE: if (start && !stop) begin
                    m_pass[i] = 0; m_phase[i] = P_GO; m_up[i] = (mode != 2'd2);
                end
                P_GO: begin m_phase[i] = P_RUN; m_wd[i] = 0; end
                P_RUN: if (m_up[i] ? up_done : down_done) begin
                    m_pass[i] = (m_pass[i] + 1) % 256;
                    if (se || (passes_of[i] != 0 && m_pass[i] == passes_of[i]))
                        m_phase[i] = P_IDLE;
                    else begin
                        m_phase[i] = P_GO;
                        if (mode == 2'd1) m_up[i] = 1;
                        else if (mode == 2'd2) m_up[i] = 0;
                        else m_up[i] = !m_up[i];
                    end
                end else begin
                    m_wd[i]++;
                    if (m_wd[i] == TIMEOUT) m_phase[i] = P_FAULT;
                end
                default: if (clear) m_phase[i] = P_IDLE;
            endcase
            if (m_phase[i] == P_IDLE || m_phase[i] == P_FAULT) m_stop[i] = 0;
            else if (ph == P_GO || ph == P_RUN) m_stop[i] = se;
            case (m_phase[i])
                P_IDLE:  m_led[i] = 0;
                P_FAULT: m_led[i] = 15;
                default: m_led[i] = m_up[i] ? int'(up_out) : int'(down_out);
            endcase
        end
    endtask

    task automatic cyc();
        if (auto_tick) begin
            tick = (tphase == 0);
            tphase = (tphase + 1) % 4;
        end
        if (model_on) begin
            model_step(0);
            model_step(1);
        end
        tick_pre = tick;
        go_u_pre = ugo[sel];
        go_d_pre = dgo[sel];
        @(posedge clk);
        #1;
        if (use_cnt && tick_pre) begin
            if (go_u_pre) begin uc = 0; ua = 1; end else if (ua && uc < 15) uc++;
            if (go_d_pre) begin dc = 0; da = 1; end else if (da && dc < 15) dc++;
            up_out = 4'(uc);       up_done = ua && uc == 15;
            down_out = 4'(15 - dc); down_done = da && dc == 15;
        end
        for (int i = 0; i < 2; i++) begin
            if (model_on) chk($sformatf("model_dut%0d", i), 32'(dv(i)), 32'(mv(i)));
            if (ugo[i] && !prev_u[i]) rise_u[i]++;
            if (dgo[i] && !prev_d[i]) rise_d[i]++;
            prev_u[i] = ugo[i];
            prev_d[i] = dgo[i];
        end
    endtask

    task automatic ticks(int n);
        int k = 0;
        while (k < n) begin
            cyc();
            if (tick_pre) k++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_btn = 0;
        tick = 0; start = 0; stop = 0; clear = 0; mode = 0;
        up_done = 0; down_done = 0; up_out = 0; down_out = 0;
        use_cnt = 0; auto_tick = 0; tphase = 0; sel = 0; model_on = 1;
        model_reset();
        @(negedge clk);
        chk("reset_dut0", 32'(dv(0)), 32'h0);
        chk("reset_dut1", 32'(dv(1)), 32'h0);
        rst_btn = 1;
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] held;
        int n;

        tbl[0]  = mk(1,1,1,0, 0, 0,0, 0,0,  ex(0,0,0,0, 0,0));
        tbl[1]  = mk(0,1,0,0, 0, 0,0, 0,0,  ex(0,0,0,0, 0,0));
        tbl[2]  = mk(1,1,0,0, 0, 0,0, 3,0,  ex(1,0,1,0, 3,0));
        tbl[3]  = mk(0,0,0,0, 0, 0,0, 5,0,  ex(1,0,1,0, 3,0));
        tbl[4]  = mk(1,0,0,0, 0, 0,0, 5,0,  ex(0,0,1,0, 5,0));
        tbl[5]  = mk(1,0,0,0, 0, 0,1, 6,0,  ex(0,0,1,0, 6,0));
        tbl[6]  = mk(1,0,0,0, 0, 1,0, 7,9,  ex(0,1,1,0, 9,1));
        tbl[7]  = mk(1,0,0,0, 0, 1,0, 0,10, ex(0,0,1,0, 10,1));
        tbl[8]  = mk(1,0,0,0, 1, 1,0, 0,11, ex(0,0,1,0, 11,1));
        tbl[9]  = mk(1,0,0,0, 1, 0,1, 2,12, ex(1,0,1,0, 2,2));
        tbl[10] = mk(1,0,1,0, 1, 0,0, 4,0,  ex(0,0,1,0, 4,2));
        tbl[11] = mk(1,0,0,0, 1, 0,0, 5,0,  ex(0,0,1,0, 5,2));
        tbl[12] = mk(1,0,0,0, 1, 1,0, 6,0,  ex(0,0,0,0, 0,3));
        tbl[13] = mk(1,0,0,0, 1, 0,0, 0,0,  ex(0,0,0,0, 0,3));
        tbl[14] = mk(1,1,0,0, 2, 0,0, 0,8,  ex(0,1,1,0, 8,0));

        do_reset();
        for (int v = 0; v < 15; v++) begin
            tick = tbl[v].tk; start = tbl[v].st; stop = tbl[v].sp; clear = tbl[v].cl;
            mode = tbl[v].md; up_done = tbl[v].ud; down_done = tbl[v].dd;
            up_out = tbl[v].uo; down_out = tbl[v].dn;
            cyc();
            chk($sformatf("vec%0d_dut0", v), 32'(dv(0)), 32'(tbl[v].exp));
            chk($sformatf("vec%0d_dut1", v), 32'(dv(1)), 32'(tbl[v].exp));
        end

        // Endless pingpong with counter models.
        do_reset();
        use_cnt = 1; auto_tick = 1; mode = 0; start = 1;
        ticks(1);
        start = 0;
        n = 0;
        while (pco[0] != 8'd4 && n < 800) begin cyc(); n++; end
        chk("pp_pass4", 32'(pco[0]), 32'd4);
        chk("pp_up_go", 32'(rise_u[0]), 32'd3);
        chk("pp_dn_go", 32'(rise_d[0]), 32'd2);

        // Up-only, three passes then auto-stop.
        do_reset();
        sel = 1; use_cnt = 1; auto_tick = 1; mode = 1; start = 1;
        ticks(1);
        start = 0;
        n = 0;
        while (bsy[1] && n < 800) begin cyc(); n++; end
        chk("uo_pass3", 32'(pco[1]), 32'd3);
        chk("uo_up_go", 32'(rise_u[1]), 32'd3);
        chk("uo_dn_go", 32'(rise_d[1]), 32'd0);
        ticks(5);
        chk("uo_hold", 32'({bsy[1], pco[1]}), 32'({1'b0, 8'd3}));

        // Graceful stop mid up-run; then start and stop together.
        do_reset();
        use_cnt = 1; auto_tick = 1; mode = 0; start = 1;
        ticks(1);
        start = 0;
        ticks(6);
        stop = 1;
        ticks(1);
        stop = 0;
        n = 0;
        while (bsy[0] && n < 400) begin cyc(); n++; end
        chk("stop_pass", 32'(pco[0]), 32'd1);
        chk("stop_no_dngo", 32'(rise_d[0]), 32'd0);
        start = 1; stop = 1;
        ticks(1);
        start = 0; stop = 0;
        chk("startstop_nogo", 32'({bsy[0], rise_u[0]}), 32'({1'b0, 32'd1}));

        // Watchdog expiry, FAULT handling, then done on the expiry tick.
        do_reset();
        tick = 1; mode = 1; start = 1;
        cyc();
        start = 0;
        cyc();
        repeat (TIMEOUT - 1) cyc();
        chk("wd_not_yet", 32'(flt[0]), 32'd0);
        cyc();
        chk("wd_fault", 32'({flt[0], bsy[0], ledo[0]}), 32'({1'b1, 1'b0, 4'hF}));
        start = 1;
        cyc();
        chk("fault_ignores_start", 32'({flt[0], ugo[0]}), 32'({1'b1, 1'b0}));
        start = 0; clear = 1;
        cyc();
        clear = 0;
        chk("fault_clear", 32'({flt[0], bsy[0], ledo[0]}), 32'h0);
        start = 1;
        cyc();
        start = 0;
        cyc();
        repeat (TIMEOUT - 1) cyc();
        up_done = 1;
        cyc();
        up_done = 0;
        chk("done_beats_wd", 32'({flt[0], ugo[0], pco[0]}), 32'({1'b0, 1'b1, 8'd1}));

        // Asynchronous reset during DN_GO and mid DN_RUN.
        do_reset();
        tick = 1; mode = 2; down_out = 7; start = 1;
        cyc();
        start = 0;
        chk("dn_go_up", 32'(dgo[0]), 32'd1);
        #2 rst_btn = 0;
        #1 chk("async_go_drop", 32'({dgo[0], dgo[1]}), 32'h0);
        model_reset();
        #2 rst_btn = 1;
        start = 1;
        cyc();
        start = 0;
        cyc(); cyc(); cyc();
        chk("in_dn_run", 32'({bsy[0], ledo[0]}), 32'({1'b1, 4'd7}));
        #3 rst_btn = 0;
        #1 chk("async_rst_dut0", 32'(dv(0)), 32'h0);
        chk("async_rst_dut1", 32'(dv(1)), 32'h0);
        model_reset();
        #2 rst_btn = 1;
        mode = 0; start = 1;
        cyc();
        start = 0;
        chk("post_rst_up_go", 32'({ugo[0], dgo[0]}), 32'({1'b1, 1'b0}));

        // Tick held low freezes everything.
        do_reset();
        tick = 1; mode = 0; up_out = 9; start = 1;
        cyc();
        start = 0;
        cyc();
        held = dv(0);
        tick = 0;
        for (int k = 0; k < 12; k++) begin
            start = 1; clear = 1; up_done = 1'($urandom); up_out = 4'($urandom);
            cyc();
        end
        chk("tick_low_hold", 32'(dv(0)), 32'(held));
        start = 0; clear = 0; up_done = 0;

        // Randomised traffic against the model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            tick = 1'($urandom_range(0, 1));
            start = ($urandom % 4) == 0;
            stop = ($urandom % 20) == 0;
            clear = ($urandom % 3) == 0;
            mode = 2'($urandom);
            up_done = ($urandom % 20) == 0;
            down_done = ($urandom % 20) == 0;
            up_out = 4'($urandom);
            down_out = 4'($urandom);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
